// File: rtl/id_ex_stage.sv
// ---------------------------------------------------------------------------
// id_ex_stage
//
// ID/EX pipeline register for the 5-stage RISC-V core. It also contains the
// load-use hazard detector and the branch-flush bubble logic.
//
// Every enabled cycle the block captures the decoded operands and control
// from ID. It presents them as registered ID_EX_* fields to EX and to the
// forwarding unit (Rs1, Rs2, alu_src). It drives the PC / IF/ID hold
// strobes, and it keeps two saturating performance counters.
//
// Ports
//   clk, arst          : rising-edge clock, asynchronous active-high reset
//   enable             : global pipeline advance; low = every register holds
//   ID_*               : decoded instruction fields from the IF/ID stage
//   EX_flush           : taken branch/jump resolved in EX; kill younger op
//   ID_EX_*            : registered fields presented to EX
//   PC_write           : 0 = hold PC (combinational)
//   IF_ID_write        : 0 = hold IF/ID register (combinational)
//   stall_count        : saturating count of load-use stall cycles
//   flush_count        : saturating count of flush cycles
//
// Handshake: there is no valid/ready pair. A stall is the backpressure.
// When PC_write / IF_ID_write are low, upstream keeps the same ID
// instruction for the next cycle. This stage loads a bubble in its place,
// so that instruction is consumed exactly once, on the first cycle the hold
// strobes read 1 with enable high.
// ---------------------------------------------------------------------------
module id_ex_stage #(
  parameter int DATA_W = 64,
  parameter int CTRL_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              arst,
  input  logic              enable,

  input  logic              ID_valid,
  input  logic [4:0]        ID_Rs1,
  input  logic [4:0]        ID_Rs2,
  input  logic [4:0]        ID_Rd,
  input  logic              ID_uses_rs2,
  input  logic [DATA_W-1:0] ID_rdata1,
  input  logic [DATA_W-1:0] ID_rdata2,
  input  logic [DATA_W-1:0] ID_imm,
  input  logic [DATA_W-1:0] ID_pc,
  input  logic              ID_reg_write,
  input  logic              ID_mem_read,
  input  logic              ID_alu_src,
  input  logic [CTRL_W-1:0] ID_ctrl,
  input  logic              EX_flush,

  output logic              ID_EX_valid,
  output logic [4:0]        ID_EX_Rs1,
  output logic [4:0]        ID_EX_Rs2,
  output logic [4:0]        ID_EX_Rd,
  output logic [DATA_W-1:0] ID_EX_rdata1,
  output logic [DATA_W-1:0] ID_EX_rdata2,
  output logic [DATA_W-1:0] ID_EX_imm,
  output logic [DATA_W-1:0] ID_EX_pc,
  output logic              ID_EX_reg_write,
  output logic              ID_EX_mem_read,
  output logic              ID_EX_alu_src,
  output logic [CTRL_W-1:0] ID_EX_ctrl,

  output logic              PC_write,
  output logic              IF_ID_write,
  output logic [CNT_W-1:0]  stall_count,
  output logic [CNT_W-1:0]  flush_count
);

  localparam logic [CNT_W-1:0] cnt_max = '1;
  localparam logic [CNT_W-1:0] cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

  logic rd_match_rs1;
  logic rd_match_rs2;
  logic hazard;
  logic stall;
  logic bubble;

  // Load-use detection. The instruction in EX is a load whose rd is needed
  // by the instruction now in ID. x0 is never a real producer. rs2 counts
  // only when the ID instruction actually reads it, so an I-type whose rs2
  // field holds immediate bits cannot stall.
  always_comb begin
    rd_match_rs1 = (ID_EX_Rd == ID_Rs1);
    rd_match_rs2 = ID_uses_rs2 & (ID_EX_Rd == ID_Rs2);
    hazard       = ID_valid & ID_EX_valid & ID_EX_mem_read &
                   (ID_EX_Rd != 5'd0) & (rd_match_rs1 | rd_match_rs2);
  end

  // A flush kills the dependent instruction anyway, so it must not also
  // freeze the PC. Otherwise the redirected fetch would be lost.
  assign stall  = hazard & ~EX_flush;
  assign bubble = EX_flush | stall;

  // Not gated by enable; these are ignored downstream while enable is low.
  // During reset ID_EX_valid is 0, so both strobes read 1.
  assign PC_write    = ~stall;
  assign IF_ID_write = ~stall;

  // Pipeline register.
  // Data and index fields other than Rd load unconditionally. On a bubble
  // their contents are don't-care, and loading them unconditionally avoids
  // a mux on the wide paths. Rd and all control fields are forced to zero
  // on a bubble or on an invalid ID slot. That way a bubble can never write
  // a register, access memory or match in the hazard / forwarding logic.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      ID_EX_valid     <= 1'b0;
      ID_EX_Rs1       <= '0;
      ID_EX_Rs2       <= '0;
      ID_EX_Rd        <= '0;
      ID_EX_rdata1    <= '0;
      ID_EX_rdata2    <= '0;
      ID_EX_imm       <= '0;
      ID_EX_pc        <= '0;
      ID_EX_reg_write <= 1'b0;
      ID_EX_mem_read  <= 1'b0;
      ID_EX_alu_src   <= 1'b0;
      ID_EX_ctrl      <= '0;
    end else if (enable) begin
      ID_EX_Rs1    <= ID_Rs1;
      ID_EX_Rs2    <= ID_Rs2;
      ID_EX_rdata1 <= ID_rdata1;
      ID_EX_rdata2 <= ID_rdata2;
      ID_EX_imm    <= ID_imm;
      ID_EX_pc     <= ID_pc;
      if (bubble) begin
        ID_EX_valid     <= 1'b0;
        ID_EX_Rd        <= '0;
        ID_EX_reg_write <= 1'b0;
        ID_EX_mem_read  <= 1'b0;
        ID_EX_alu_src   <= 1'b0;
        ID_EX_ctrl      <= '0;
      end else begin
        ID_EX_valid     <= ID_valid;
        ID_EX_Rd        <= ID_Rd;
        ID_EX_reg_write <= ID_valid & ID_reg_write;
        ID_EX_mem_read  <= ID_valid & ID_mem_read;
        ID_EX_alu_src   <= ID_valid & ID_alu_src;
        ID_EX_ctrl      <= ID_valid ? ID_ctrl : '0;
      end
    end
  end

  // Event counters. They saturate at all-ones. stall already excludes
  // flush cycles, so a cycle with both a flush and a hazard is counted as
  // a flush only.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      stall_count <= '0;
      flush_count <= '0;
    end else if (enable) begin
      if (stall && (stall_count != cnt_max)) begin
        stall_count <= stall_count + cnt_one;
      end
      if (EX_flush && (flush_count != cnt_max)) begin
        flush_count <= flush_count + cnt_one;
      end
    end
  end

  // After any enabled stall or flush, EX must hold a harmless bubble.
  a_bubble_after_stall : assert property (
    @(posedge clk) disable iff (arst)
    (enable && stall) |=> (!ID_EX_valid && !ID_EX_mem_read && !ID_EX_reg_write)
  );

  a_bubble_after_flush : assert property (
    @(posedge clk) disable iff (arst)
    (enable && EX_flush) |=> (!ID_EX_valid && (ID_EX_Rd == 5'd0))
  );

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;

  localparam int DATA_W = 64;
  localparam int CTRL_W = 8;
  localparam int CNT_W  = 4;
  localparam int NV     = 21;

  // clock / reset
  logic clk = 1'b0;
  logic arst;
  always #5 clk = ~clk;

  logic              enable;
  logic              id_valid;
  logic [4:0]        id_rs1, id_rs2, id_rd;
  logic              id_uses_rs2;
  logic [DATA_W-1:0] id_rdata1, id_rdata2, id_imm, id_pc;
  logic              id_reg_write, id_mem_read, id_alu_src;
  logic [CTRL_W-1:0] id_ctrl;
  logic              ex_flush;

  logic              ex_valid;
  logic [4:0]        ex_rs1, ex_rs2, ex_rd;
  logic [DATA_W-1:0] ex_rdata1, ex_rdata2, ex_imm, ex_pc;
  logic              ex_reg_write, ex_mem_read, ex_alu_src;
  logic [CTRL_W-1:0] ex_ctrl;
  logic              pc_write, if_id_write;
  logic [CNT_W-1:0]  stall_count, flush_count;

  id_ex_stage #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .arst(arst), .enable(enable),
    .ID_valid(id_valid), .ID_Rs1(id_rs1), .ID_Rs2(id_rs2), .ID_Rd(id_rd),
    .ID_uses_rs2(id_uses_rs2), .ID_rdata1(id_rdata1), .ID_rdata2(id_rdata2),
    .ID_imm(id_imm), .ID_pc(id_pc), .ID_reg_write(id_reg_write),
    .ID_mem_read(id_mem_read), .ID_alu_src(id_alu_src), .ID_ctrl(id_ctrl),
    .EX_flush(ex_flush),
    .ID_EX_valid(ex_valid), .ID_EX_Rs1(ex_rs1), .ID_EX_Rs2(ex_rs2),
    .ID_EX_Rd(ex_rd), .ID_EX_rdata1(ex_rdata1), .ID_EX_rdata2(ex_rdata2),
    .ID_EX_imm(ex_imm), .ID_EX_pc(ex_pc), .ID_EX_reg_write(ex_reg_write),
    .ID_EX_mem_read(ex_mem_read), .ID_EX_alu_src(ex_alu_src),
    .ID_EX_ctrl(ex_ctrl), .PC_write(pc_write), .IF_ID_write(if_id_write),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  // stimulus vector: inputs plus expected outputs
  typedef struct {
    logic        en, v;
    logic [4:0]  rs1, rs2, rd;
    logic        u, mr, rw, as;
    logic [7:0]  ctrl;
    logic        fl;
    logic        pcw;
    logic        ev;
    logic [4:0]  erd;
    logic        erw, emr;
    logic [7:0]  ectrl;
    logic [3:0]  esc, efc;
  } vec_t;

  // scoreboard entry
  typedef struct {
    logic              valid, rw, mr, as, chk_data;
    logic [4:0]        rd, rs1, rs2;
    logic [7:0]        ctrl;
    logic [3:0]        sc, fc;
    logic [DATA_W-1:0] d1, d2, imm, pc;
  } exp_t;

  vec_t vecs[NV];
  exp_t exp_q[$];

  int tests  = 0;
  int failed = 0;

  // last captured valid instruction, used as the expectation while holding
  logic              last_as;
  logic [4:0]        last_rs1, last_rs2;
  logic [DATA_W-1:0] last_d1, last_d2, last_imm, last_pc;

  function automatic vec_t mk(
    input logic en, input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
    input logic [4:0] rd, input logic u, input logic mr, input logic rw,
    input logic as, input logic [7:0] ctrl, input logic fl,
    input logic pcw, input logic ev, input logic [4:0] erd, input logic erw,
    input logic emr, input logic [7:0] ectrl, input logic [3:0] esc,
    input logic [3:0] efc);
    vec_t r;
    r.en = en; r.v = v; r.rs1 = rs1; r.rs2 = rs2; r.rd = rd; r.u = u;
    r.mr = mr; r.rw = rw; r.as = as; r.ctrl = ctrl; r.fl = fl;
    r.pcw = pcw; r.ev = ev; r.erd = erd; r.erw = erw; r.emr = emr;
    r.ectrl = ectrl; r.esc = esc; r.efc = efc;
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // driver
  task automatic drive(input vec_t v);
    enable       = v.en;
    id_valid     = v.v;
    id_rs1       = v.rs1;
    id_rs2       = v.rs2;
    id_rd        = v.rd;
    id_uses_rs2  = v.u;
    id_mem_read  = v.mr;
    id_reg_write = v.rw;
    id_alu_src   = v.as;
    id_ctrl      = v.ctrl;
    ex_flush     = v.fl;
    id_rdata1    = {$urandom, $urandom};
    id_rdata2    = {$urandom, $urandom};
    id_imm       = {$urandom, $urandom};
    id_pc        = {$urandom, $urandom};
  endtask

  task automatic check_entry(input exp_t e);
    chk("ex_valid", ex_valid, e.valid);
    chk("ex_rd", ex_rd, e.rd);
    chk("ex_reg_write", ex_reg_write, e.rw);
    chk("ex_mem_read", ex_mem_read, e.mr);
    chk("ex_ctrl", ex_ctrl, e.ctrl);
    chk("stall_count", stall_count, e.sc);
    chk("flush_count", flush_count, e.fc);
    if (e.chk_data) begin
      chk("ex_alu_src", ex_alu_src, e.as);
      chk("ex_rs1", ex_rs1, e.rs1);
      chk("ex_rs2", ex_rs2, e.rs2);
      chk("ex_rdata1", ex_rdata1, e.d1);
      chk("ex_rdata2", ex_rdata2, e.d2);
      chk("ex_imm", ex_imm, e.imm);
      chk("ex_pc", ex_pc, e.pc);
    end
  endtask

  initial begin
    exp_t e;
    int   exp_sc;

    // reset
    arst = 1'b1;
    drive(mk(0,0,0,0,0,0,0,0,0,8'h00,0, 1,0,0,0,0,0,0,0));
    #12;
    chk("rst_valid", ex_valid, 0);
    chk("rst_rd", ex_rd, 0);
    chk("rst_reg_write", ex_reg_write, 0);
    chk("rst_mem_read", ex_mem_read, 0);
    chk("rst_ctrl", ex_ctrl, 0);
    chk("rst_rdata1", ex_rdata1, 0);
    chk("rst_pc", ex_pc, 0);
    chk("rst_stall_count", stall_count, 0);
    chk("rst_flush_count", flush_count, 0);
    chk("rst_pc_write", pc_write, 1);
    chk("rst_if_id_write", if_id_write, 1);
    @(negedge clk);
    arst = 1'b0;
    @(posedge clk); #1;

    // en v rs1 rs2 rd u mr rw as ctrl fl | pcw ev erd erw emr ectrl esc efc
    // back-to-back ALU ops, then an invalid slot
    vecs[0]  = mk(1,1,1,2,3,1,0,1,0,8'h11,0, 1,1,3,1,0,8'h11,0,0);
    vecs[1]  = mk(1,1,3,4,6,1,0,1,1,8'h22,0, 1,1,6,1,0,8'h22,0,0);
    vecs[2]  = mk(1,0,7,8,0,0,1,1,1,8'h33,0, 1,0,0,0,0,8'h00,0,0);
    // load-use on rs1
    vecs[3]  = mk(1,1,1,0,5,0,1,1,1,8'h44,0, 1,1,5,1,1,8'h44,0,0);
    vecs[4]  = mk(1,1,5,2,7,1,0,1,0,8'h55,0, 0,0,0,0,0,8'h00,1,0);
    vecs[5]  = mk(1,1,5,2,7,1,0,1,0,8'h55,0, 1,1,7,1,0,8'h55,1,0);
    // I-type whose rs2 field matches but is unused; load to x0
    vecs[6]  = mk(1,1,2,0,5,0,1,1,1,8'h66,0, 1,1,5,1,1,8'h66,1,0);
    vecs[7]  = mk(1,1,1,5,8,0,0,1,1,8'h77,0, 1,1,8,1,0,8'h77,1,0);
    vecs[8]  = mk(1,1,3,0,0,0,1,1,1,8'h88,0, 1,1,0,1,1,8'h88,1,0);
    vecs[9]  = mk(1,1,0,0,9,1,0,1,0,8'h99,0, 1,1,9,1,0,8'h99,1,0);
    // load-use on rs2
    vecs[10] = mk(1,1,1,0,6,0,1,1,1,8'h10,0, 1,1,6,1,1,8'h10,1,0);
    vecs[11] = mk(1,1,2,6,10,1,0,1,0,8'h20,0, 0,0,0,0,0,8'h00,2,0);
    vecs[12] = mk(1,1,2,6,10,1,0,1,0,8'h20,0, 1,1,10,1,0,8'h20,2,0);
    // hazard together with flush: flush wins
    vecs[13] = mk(1,1,1,0,7,0,1,1,1,8'h30,0, 1,1,7,1,1,8'h30,2,0);
    vecs[14] = mk(1,1,7,0,11,0,0,1,0,8'h40,1, 1,0,0,0,0,8'h00,2,1);
    vecs[15] = mk(1,1,1,0,12,0,0,1,0,8'h50,0, 1,1,12,1,0,8'h50,2,1);
    // enable low for 3 cycles with toggling inputs, then resume
    vecs[16] = mk(0,1,12,0,13,0,0,1,1,8'h60,1, 1,1,12,1,0,8'h50,2,1);
    vecs[17] = mk(0,0,3,4,14,1,1,0,0,8'h70,0, 1,1,12,1,0,8'h50,2,1);
    vecs[18] = mk(0,1,5,6,15,1,1,1,1,8'h71,0, 1,1,12,1,0,8'h50,2,1);
    vecs[19] = mk(1,1,3,0,16,0,0,0,1,8'h72,0, 1,1,16,0,0,8'h72,2,1);
    // plain flush
    vecs[20] = mk(1,1,4,0,17,0,0,1,0,8'h73,1, 1,0,0,0,0,8'h00,2,2);

    last_as = 0; last_rs1 = 0; last_rs2 = 0;
    last_d1 = 0; last_d2 = 0; last_imm = 0; last_pc = 0;

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i]);
      #1;
      chk($sformatf("pc_write[%0d]", i), pc_write, vecs[i].pcw);
      chk($sformatf("if_id_write[%0d]", i), if_id_write, vecs[i].pcw);
      if (vecs[i].en && vecs[i].ev) begin
        last_as = id_alu_src; last_rs1 = id_rs1; last_rs2 = id_rs2;
        last_d1 = id_rdata1; last_d2 = id_rdata2; last_imm = id_imm; last_pc = id_pc;
      end
      e.valid = vecs[i].ev; e.rd = vecs[i].erd; e.rw = vecs[i].erw;
      e.mr = vecs[i].emr; e.ctrl = vecs[i].ectrl; e.sc = vecs[i].esc;
      e.fc = vecs[i].efc; e.chk_data = vecs[i].ev;
      e.as = last_as; e.rs1 = last_rs1; e.rs2 = last_rs2;
      e.d1 = last_d1; e.d2 = last_d2; e.imm = last_imm; e.pc = last_pc;
      exp_q.push_back(e);
      @(posedge clk); #1;
      if (exp_q.size() == 0) begin
        chk("sb_underflow", 1, 0);
      end else begin
        check_entry(exp_q.pop_front());
      end
    end
    chk("sb_empty", exp_q.size(), 0);

    // saturation: alternate load / dependent op, one stall per pair
    exp_sc = 2;
    for (int k = 0; k < (1 << CNT_W) + 5; k++) begin
      drive(mk(1,1,1,0,5,0,1,1,1,8'h01,0, 1,1,5,1,1,8'h01,0,0));
      @(posedge clk); #1;
      drive(mk(1,1,5,0,7,0,0,1,0,8'h02,0, 0,0,0,0,0,8'h00,0,0));
      #1;
      chk("sat_pc_write", pc_write, 0);
      @(posedge clk); #1;
      exp_sc = (exp_sc < 15) ? exp_sc + 1 : 15;
      chk("sat_stall_count", stall_count, exp_sc);
    end
    chk("sat_final", stall_count, 15);
    chk("sat_flush_count", flush_count, 2);

    // reset asserted mid-stall, between clock edges
    drive(mk(1,1,1,0,5,0,1,1,1,8'h03,0, 1,1,5,1,1,8'h03,0,0));
    @(posedge clk); #1;
    drive(mk(1,1,5,0,7,0,0,1,0,8'h04,0, 0,0,0,0,0,8'h00,0,0));
    #1;
    chk("mid_pc_write_before", pc_write, 0);
    #2;
    arst = 1'b1;
    #1;
    chk("mid_rst_valid", ex_valid, 0);
    chk("mid_rst_rd", ex_rd, 0);
    chk("mid_rst_mem_read", ex_mem_read, 0);
    chk("mid_rst_ctrl", ex_ctrl, 0);
    chk("mid_rst_stall_count", stall_count, 0);
    chk("mid_rst_flush_count", flush_count, 0);
    chk("mid_rst_pc_write", pc_write, 1);
    #2;
    arst = 1'b0;
    #1;
    chk("post_rst_pc_write", pc_write, 1);
    @(posedge clk); #1;
    chk("post_rst_valid", ex_valid, 1);
    chk("post_rst_rd", ex_rd, 7);
    chk("post_rst_ctrl", ex_ctrl, 8'h04);
    chk("post_rst_stall_count", stall_count, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register for the 5-stage RISC-V core, with load-use hazard detection and branch flush.
- Captures decoded operands and control from ID each cycle.
- Presents registered ID_EX_* fields to the EX stage, including ID_EX_Rs1, ID_EX_Rs2 and ALU_src for the forwarding unit.
- Generates the stall signals for the PC and the IF/ID register, and keeps saturating stall and flush event counters for performance analysis.

Parameters:
- DATA_W, 64, width of register data, immediate and PC.
- CTRL_W, 8, width of the opaque EX/MEM/WB control bundle passed through unchanged.
- CNT_W, 16, width of each saturating event counter.

Ports:
- clk  in  1  core clock, rising edge.
- arst  in  1  reset; asynchronous, active-high.
- enable  in  1  global pipeline advance. When low, all state holds.
- ID_valid  in  1  IF/ID holds a real instruction.
- ID_Rs1  in  5  decoded rs1 index.
- ID_Rs2  in  5  decoded rs2 index.
- ID_Rd  in  5  decoded rd index.
- ID_uses_rs2  in  1  instruction reads rs2 (R-type, store, branch).
- ID_rdata1  in  DATA_W  register file read port 1.
- ID_rdata2  in  DATA_W  register file read port 2.
- ID_imm  in  DATA_W  sign-extended immediate.
- ID_pc  in  DATA_W  instruction PC.
- ID_reg_write  in  1  control: writes rd.
- ID_mem_read  in  1  control: load.
- ID_alu_src  in  1  control: operand B is the immediate.
- ID_ctrl  in  CTRL_W  remaining control bundle.
- EX_flush  in  1  branch/jump resolved taken in EX; kill younger instructions.
- ID_EX_valid  out  1  registered valid.
- ID_EX_Rs1  out  5  registered rs1 index.
- ID_EX_Rs2  out  5  registered rs2 index.
- ID_EX_Rd  out  5  registered rd index.
- ID_EX_rdata1  out  DATA_W  registered read data 1.
- ID_EX_rdata2  out  DATA_W  registered read data 2.
- ID_EX_imm  out  DATA_W  registered immediate.
- ID_EX_pc  out  DATA_W  registered PC.
- ID_EX_reg_write  out  1  registered control.
- ID_EX_mem_read  out  1  registered control.
- ID_EX_alu_src  out  1  registered control.
- ID_EX_ctrl  out  CTRL_W  registered control bundle.
- PC_write  out  1  0 = hold PC.
- IF_ID_write  out  1  0 = hold IF/ID register.
- stall_count  out  CNT_W  saturating count of load-use stall cycles.
- flush_count  out  CNT_W  saturating count of flush cycles.

Behaviour:
- Reset (arst high, asynchronous): every registered output and both counters go to 0.
  - PC_write and IF_ID_write are combinational and read 1 during reset.
- Hazard detection (combinational). hazard = ID_valid & ID_EX_valid & ID_EX_mem_read & (ID_EX_Rd != 0) & ((ID_EX_Rd == ID_Rs1) | (ID_uses_rs2 & (ID_EX_Rd == ID_Rs2))).
- Stall outputs: stall = hazard & ~EX_flush. PC_write = IF_ID_write = ~stall.
  - enable does not gate these outputs; they are don't-care to the rest of the pipe while enable is low.
- Register update on the rising clk edge when enable = 1, in priority order:
  1. EX_flush = 1: insert bubble. ID_EX_valid, reg_write and mem_read go to 0, ID_EX_ctrl goes to 0, and ID_EX_Rd goes to 0. Flush beats stall.
  2. stall = 1: insert bubble, same zeroing as flush. The ID instruction is retained upstream and re-presented next cycle.
  3. Otherwise: capture all ID_* inputs. ID_EX_valid = ID_valid. Control fields are zeroed if ID_valid = 0.
- Bubble data fields: on a bubble, data and index fields other than Rd may hold any value. Verification checks only valid, Rd and control on bubbles.
- enable = 0: all registers and counters hold. No bubble is inserted.
- Latency: exactly 1 cycle ID to EX. A load-use hazard costs exactly 1 bubble. After the bubble the hazard clears because ID_EX_mem_read = 0.
- Counters, advanced only when enable = 1:
  - stall_count += 1 on a stall cycle.
  - flush_count += 1 on a flush cycle.
  - Both saturate at 2^CNT_W − 1 with no wrap.
  - A cycle with flush and hazard together counts as flush only.
- Reset mid-stall: state clears immediately and PC_write returns to 1 at once. No bubble is owed after release.
- rd = x0 never triggers a hazard.

Test Plan:
1. Reset, then a back-to-back ALU sequence with no loads.
   - Outputs track inputs with 1-cycle delay.
   - PC_write = 1 throughout; both counters stay 0.
2. Load-use on rs1: lw x5 (ID_EX_mem_read = 1, Rd = 5), then ID_Rs1 = 5.
   - PC_write = IF_ID_write = 0 for one cycle.
   - Next edge: ID_EX_valid = 0, ID_EX_reg_write = 0.
   - Following edge: the dependent instruction is captured.
   - stall_count = 1.
3. Load followed by an I-type with ID_Rs2 = 5 and ID_uses_rs2 = 0: no stall.
   - Same load with Rd = 0 and ID_Rs1 = 0: no stall.
4. Hazard condition and EX_flush = 1 in the same cycle.
   - PC_write = 1 and a bubble is inserted.
   - flush_count = 1, stall_count unchanged.
5. enable = 0 for 3 cycles while inputs toggle.
   - All ID_EX_* outputs and counters are unchanged.
   - Resume with enable = 1: capture next edge.
6. Force 2^CNT_W + 5 stall cycles (CNT_W = 4 build): stall_count holds at 15.
   - Assert arst mid-stall: outputs go to 0 asynchronously, before the next clk edge.
